rsp_capture_ctrl: RTL and testbench
===================================

# rsp_capture_ctrl

Capture controller for the range/chirp preprocessing datapath. It selects one of N_SRC sample taps and counts that tap's valid samples into fixed-length packets. It captures exactly one chosen packet into a small show-ahead FIFO and drains it over a ready/valid port to a downstream sink (BRAM dump, UART/DMA bridge or bench logger). Capture is sequenced by a start pulse, and completion is reported with a done pulse.

## Interface
Parameters:
- N_SRC, 4, number of selectable sample taps (≥2)
- DATA_WIDTH, 16, sample width
- PKT_LEN, 1024, samples per packet (≥2)
- CNT_W, 16, width of packet-index and sample counters
- FIFO_DEPTH, 16, capture FIFO entries (power of 2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle start pulse; latches cfg_src/cfg_pkt_sel
- cfg_src  in  $clog2(N_SRC)  tap to monitor
- cfg_pkt_sel  in  CNT_W  1-based packet index to capture (0 treated as 1)
- src_valid  in  N_SRC  per-tap sample strobe
- src_data  in  N_SRC*DATA_WIDTH  tap i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- cap_valid  out  1  output beat available
- cap_data  out  DATA_WIDTH  output sample
- cap_last  out  1  marks final sample of captured packet
- cap_ready  in  1  sink accepts beat when cap_valid&cap_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: ≥1 captured sample dropped on FIFO full

## Operation
- The FSM has five states: IDLE, ARM, CAPTURE, DRAIN, DONE.
- **IDLE:** cfg_start latches src_sel/pkt_sel, clears counters, FIFO and overflow, then → ARM. cfg_start in any other state is ignored.
- **Sample accept:** a sample counts only when src_valid[src_sel]=1. Other taps are ignored entirely.
- **Counters:** samp_cnt runs 0..PKT_LEN-1. On an accepted sample with samp_cnt==PKT_LEN-1 it wraps to 0 and pkt_idx increments. pkt_idx starts at 1. pkt_idx saturates at all-ones and does not wrap.
- **ARM:** counts only. When pkt_idx==pkt_sel at an accepted sample with samp_cnt==0 → CAPTURE. That sample is the packet's first and is captured.
  - With pkt_sel=1, the first accepted sample after start is captured.
- **CAPTURE:** each accepted sample enters a 1-stage input register (data, last=(samp_cnt==PKT_LEN-1)) and is written into the FIFO the next cycle.
  - If the FIFO is full at write time, the sample is dropped and overflow is set. Counting continues.
  - After the last sample is accepted → DRAIN.
- **DRAIN:** waits until the input register and FIFO are both empty and the last beat has been handshaken → DONE.
  - If the last sample was dropped, cap_last never appears. DRAIN then exits on FIFO-empty after the input register flushes.
- **DONE:** done=1 for one cycle → IDLE.
- **FIFO:** show-ahead. cap_valid = !empty, and cap_data/cap_last come from the head entry.
  - Pop on cap_valid&cap_ready.
  - Simultaneous push and pop while full is allowed: the pop frees the slot and no drop occurs.
- **Reset:** rst in any state returns the block to IDLE and flushes the FIFO and input register.
  - Output reset values: cap_valid=0, cap_data=0, cap_last=0, busy=0, done=0, overflow=0.
- **overflow lifetime:** overflow holds through DONE and IDLE until the next accepted cfg_start.

## Timing
- cfg_start at cycle t → busy=1 at t+1. A sample presented at t is not counted; the first countable sample is at t+1.
- Latency: a captured sample accepted at cycle t is written to the FIFO at t+1 and gives cap_valid=1 at t+2 (FIFO previously empty). Throughput is 1 sample/cycle.
- cap_data/cap_last are stable while cap_valid=1 and cap_ready=0.
- Last handshake (cap_last beat) at cycle t → done=1 at t+1 (DRAIN→DONE registered) and busy=0 at t+2.
- Overflow is set in the cycle after the dropped write attempt.
- All outputs are registered except cap_valid, cap_data and cap_last, which come directly from FIFO head registers and have no combinational path from inputs.

## Test plan
- **Single packet, free-flowing:** N_SRC=4, PKT_LEN=8, cfg_src=2, cfg_pkt_sel=2, tap 2 streams data 0..23 continuously, cap_ready=1.
  - Required: exactly 8 beats 8..15, cap_last only on 15, done once, overflow=0.
- **Gapped valid and tap isolation:** tap 2 valid toggles every other cycle while taps 0/1/3 stream junk every cycle.
  - Required: captured data is identical to the free-flowing case; junk values never appear.
- **Backpressure overflow:** FIFO_DEPTH=4, PKT_LEN=8, cap_ready=0 throughout CAPTURE.
  - Required: first 4 samples are held, overflow=1, and draining after cap_ready=1 yields 4 beats with no cap_last.
  - done follows and overflow stays 1 until the next start.
- **Full + simultaneous pop:** FIFO full with cap_ready=1 during each push.
  - Required: no drop, overflow=0, all 8 beats delivered in order.
- **Start ignored while busy:** a second cfg_start with a different cfg_src arrives during ARM.
  - Required: original source and packet are captured unchanged.
- **Reset mid-capture:** rst pulsed after 3 beats are pushed.
  - Required: next cycle all outputs are 0 and the state is IDLE. A new start with cfg_pkt_sel=0 captures packet 1 completely.

Source files
------------

// File: rtl/rsp_capture_ctrl.sv
// Capture controller: counts one tap's samples into fixed-length packets, captures the chosen
// packet through a one-stage input register into a show-ahead FIFO and drains it ready/valid.
module rsp_capture_ctrl #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 1024,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [$clog2(N_SRC)-1:0]      cfg_src,
  input  logic [CNT_W-1:0]              cfg_pkt_sel,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*DATA_WIDTH-1:0]   src_data,
  output logic                          cap_valid,
  output logic [DATA_WIDTH-1:0]         cap_data,
  output logic                          cap_last,
  input  logic                          cap_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned SrcW  = $clog2(N_SRC);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CNT_W-1:0] LastSamp = CNT_W'(PKT_LEN - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StArm, StCapture, StDrain, StDone} state_e;

  state_e                r_state, w_state_d;
  logic                  r_busy, r_done, w_busy_d, w_done_d;
  logic [SrcW-1:0]       r_src_sel;
  logic [CNT_W-1:0]      r_pkt_sel, r_pkt_idx, r_samp_cnt;
  logic                  r_in_vld, r_in_last, r_overflow;
  logic [DATA_WIDTH-1:0] r_in_data;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [AddrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;

  logic                  w_start, w_acc, w_cap, w_samp_last, w_empty, w_full;
  logic                  w_pop, w_push, w_drop;
  logic [DATA_WIDTH-1:0] w_sel_data;

  assign w_start     = (r_state == StIdle) && cfg_start;
  assign w_acc       = src_valid[r_src_sel] && (r_state == StArm || r_state == StCapture);
  assign w_samp_last = (r_samp_cnt == LastSamp);
  // In ARM only the first sample of the selected packet opens the capture window.
  assign w_cap       = w_acc && (r_state == StCapture ||
                                 (r_pkt_idx == r_pkt_sel && r_samp_cnt == '0));
  assign w_sel_data  = src_data[r_src_sel*DATA_WIDTH +: DATA_WIDTH];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCnt);
  assign w_pop   = !w_empty && cap_ready;
  assign w_push  = r_in_vld && (!w_full || w_pop);
  assign w_drop  = r_in_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (cfg_start) w_state_d = StArm;
      StArm:     if (w_cap) w_state_d = StCapture;
      StCapture: if (w_cap && w_samp_last) w_state_d = StDrain;
      // Exit in the same cycle the final beat leaves, so done follows it by one cycle.
      StDrain:   if (!r_in_vld && (w_empty || (r_count == CntW'(1) && w_pop)))
                   w_state_d = StDone;
      StDone:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_sel  <= '0;
      r_pkt_sel  <= CNT_W'(1);
      r_pkt_idx  <= CNT_W'(1);
      r_samp_cnt <= '0;
      r_in_vld   <= 1'b0;
      r_in_last  <= 1'b0;
      r_in_data  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_in_vld  <= w_cap;
      r_in_last <= w_samp_last;
      r_in_data <= w_sel_data;
      if (w_start) begin
        r_src_sel  <= cfg_src;
        r_pkt_sel  <= (cfg_pkt_sel == '0) ? CNT_W'(1) : cfg_pkt_sel;
        r_pkt_idx  <= CNT_W'(1);
        r_samp_cnt <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_acc) begin
          if (w_samp_last) begin
            r_samp_cnt <= '0;
            if (r_pkt_idx != '1) r_pkt_idx <= r_pkt_idx + 1'b1;
          end else begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= r_in_data;
      r_mem_last[r_wr_ptr] <= r_in_last;
    end
  end

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign cap_valid = !w_empty;
  assign cap_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign cap_last  = !w_empty && r_mem_last[r_rd_ptr];
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rsp_capture_ctrl.sv
// Directed bench for rsp_capture_ctrl: N_SRC=4, PKT_LEN=8, FIFO_DEPTH=4, tap 2 carries 0,1,2..
// while other taps carry junk tagged in the top nibble.
module tb_rsp_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [1:0]  cfg_src = 2'd0;
  logic [15:0] cfg_pkt_sel = 16'd0;
  logic [3:0]  src_valid = 4'd0;
  logic [63:0] src_data = 64'd0;
  logic        cap_valid, cap_last, cap_ready = 1'b1;
  logic [15:0] cap_data;
  logic        busy, done, overflow;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  logic [16:0] beats [$];

  rsp_capture_ctrl #(
    .N_SRC(4), .DATA_WIDTH(16), .PKT_LEN(8), .CNT_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_pkt_sel(cfg_pkt_sel), .src_valid(src_valid), .src_data(src_data),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_last(cap_last), .cap_ready(cap_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_valid && cap_ready) begin
      beats.push_back({cap_last, cap_data});
      if (cap_last) last_hs_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] src, input logic [15:0] sel, input string tag);
    beats.delete();
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_src = src; cfg_pkt_sel = sel;
    src_valid = 4'b1111; src_data = {4{16'h7777}};
    @(posedge clk); #1;
    cfg_start = 1'b0; src_valid = 4'b0000;
    @(negedge clk);
    check({tag, " busy after start"}, 32'(busy), 32'd1);
  endtask

  // Tap 2 gets 0..n-1 (every other cycle when gap), other taps junk every cycle.
  task automatic stream(input int n, input bit gap, input int ready_at, input int restart_at);
    int k = 0;
    int c = 0;
    logic v2;
    logic [15:0] j;
    while (k < n) begin
      @(posedge clk); #1;
      v2 = gap ? (c % 2 == 0) : 1'b1;
      j = 16'(c & 32'h0FFF);
      src_valid = {1'b1, v2, 1'b1, 1'b1};
      src_data  = {16'hC000 | j, 16'(k), 16'hB000 | j, 16'hA000 | j};
      cfg_start = (k == restart_at);
      cfg_src = (k == restart_at) ? 2'd1 : 2'd2;
      cfg_pkt_sel = 16'd1;
      if (k == ready_at) cap_ready = 1'b1;
      if (v2) k++;
      c++;
    end
    @(posedge clk); #1;
    src_valid = 4'b0000; cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit has_last);
    int n = 0;
    bit seen = 1'b0;
    int base = done_cnt;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " busy low after done"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, " done count"}, 32'(done_cnt - base), 32'd1);
    if (has_last) check({tag, " done after last"}, 32'(done_cyc - last_hs_cyc), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input int n, input int first, input bit has_last);
    check({tag, " beats"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < n && i < beats.size(); i++) begin
      check($sformatf("%s data[%0d]", tag, i), 32'(beats[i][15:0]), 32'(first + i));
      check($sformatf("%s last[%0d]", tag, i), 32'(beats[i][16]), 32'(has_last && i == n - 1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst cap_valid", 32'(cap_valid), 32'd0);
    check("rst cap_data", 32'(cap_data), 32'd0);
    check("rst cap_last", 32'(cap_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);

    // Free-flowing, packet 2 of tap 2.
    start(2'd2, 16'd2, "t1");
    stream(16, 1'b0, -1, -1);
    wait_done("t1", 1'b1);
    check_pkt("t1", 8, 8, 1'b1);
    check("t1 overflow", 32'(overflow), 32'd0);

    // Gapped tap 2 with junk on the others.
    start(2'd2, 16'd2, "t2");
    stream(16, 1'b1, -1, -1);
    wait_done("t2", 1'b1);
    check_pkt("t2", 8, 8, 1'b1);

    // Backpressure: only 4 of 8 fit, last is dropped.
    cap_ready = 1'b0;
    start(2'd2, 16'd1, "t3");
    stream(8, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    check("t3 overflow set", 32'(overflow), 32'd1);
    check("t3 busy in drain", 32'(busy), 32'd1);
    check("t3 head valid", 32'(cap_valid), 32'd1);
    check("t3 head data", 32'(cap_data), 32'd0);
    @(posedge clk); #1 cap_ready = 1'b1;
    wait_done("t3", 1'b0);
    check_pkt("t3", 4, 0, 1'b0);
    check("t3 overflow sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on every push from the 5th sample on.
    cap_ready = 1'b0;
    start(2'd2, 16'd1, "t4");
    check("t4 overflow cleared", 32'(overflow), 32'd0);
    stream(8, 1'b0, 5, -1);
    wait_done("t4", 1'b1);
    check_pkt("t4", 8, 0, 1'b1);
    check("t4 overflow", 32'(overflow), 32'd0);

    // Second start during ARM selecting tap 1 / packet 1 must be ignored.
    start(2'd2, 16'd2, "t5");
    stream(16, 1'b0, -1, 3);
    wait_done("t5", 1'b1);
    check_pkt("t5", 8, 8, 1'b1);

    // Reset with three samples sitting in the FIFO.
    cap_ready = 1'b0;
    start(2'd2, 16'd2, "t6");
    stream(11, 1'b0, -1, -1);
    @(negedge clk);
    check("t6 pre-rst valid", 32'(cap_valid), 32'd1);
    check("t6 pre-rst head", 32'(cap_data), 32'd8);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6 rst cap_valid", 32'(cap_valid), 32'd0);
    check("t6 rst cap_data", 32'(cap_data), 32'd0);
    check("t6 rst cap_last", 32'(cap_last), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst done", 32'(done), 32'd0);
    check("t6 rst overflow", 32'(overflow), 32'd0);
    cap_ready = 1'b1;
    start(2'd2, 16'd0, "t6b");
    stream(8, 1'b0, -1, -1);
    wait_done("t6b", 1'b1);
    check_pkt("t6b", 8, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
